// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message schedule.
package sha256_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned IDX_W       = 6;
  localparam int unsigned SCHED_WORDS = 64;
  localparam int unsigned BLOCK_WORDS = 16;
  localparam int unsigned STALL_CNT_W = 16;

  // sig0(x) = ROTR7 ^ ROTR18 ^ SHR3; sig1(x) = ROTR17 ^ ROTR19 ^ SHR10
  localparam int unsigned SIG0_ROT_A = 7;
  localparam int unsigned SIG0_ROT_B = 18;
  localparam int unsigned SIG0_SHR   = 3;
  localparam int unsigned SIG1_ROT_A = 17;
  localparam int unsigned SIG1_ROT_B = 19;
  localparam int unsigned SIG1_SHR   = 10;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    ST_LOAD   = 1'b0,
    ST_EXPAND = 1'b1
  } state_t;

  // Rotate right by a constant amount in 1..WORD_W-1.
  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

endpackage

// File: rtl/sha256_small_sigma.sv
// SHA-256 small sigma function; SEL = 0 gives sig0, SEL = 1 gives sig1.
module sha256_small_sigma
  import sha256_pkg::*;
#(
  parameter int unsigned SEL = 0
) (
  input  logic [WORD_W-1:0] x,
  output logic [WORD_W-1:0] y
);

  localparam int unsigned ROT_A = (SEL == 0) ? SIG0_ROT_A : SIG1_ROT_A;
  localparam int unsigned ROT_B = (SEL == 0) ? SIG0_ROT_B : SIG1_ROT_B;
  localparam int unsigned SHR_N = (SEL == 0) ? SIG0_SHR   : SIG1_SHR;

  // Two rotations and one logical shift, xor-combined.
  assign y = rotr(x, ROT_A) ^ rotr(x, ROT_B) ^ (x >> SHR_N);

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: takes 16 message words, emits W[0..63] through a
// one-word registered output slot with valid/ready on both sides.
// Optional macro SHA256_SCHED_STALL_CNT_EN adds a saturating stall_cnt output.
module sha256_msg_schedule
  import sha256_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last
`ifdef SHA256_SCHED_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  localparam logic [IDX_W-1:0] IDX_BLOCK_END = IDX_W'(BLOCK_WORDS - 1);
  localparam logic [IDX_W-1:0] IDX_SCHED_END = IDX_W'(SCHED_WORDS - 1);

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] cnt_q;
  word_t            win [BLOCK_WORDS];
  logic             slot_free;
  logic             load;
  word_t            load_word;
  word_t            expand_word;
  word_t            sig0_w;
  word_t            sig1_w;

  assign slot_free = !out_valid || out_ready;

  sha256_small_sigma #(.SEL(0)) u_sig0 (
    .x (win[1]),
    .y (sig0_w)
  );

  sha256_small_sigma #(.SEL(1)) u_sig1 (
    .x (win[14]),
    .y (sig1_w)
  );

  // W[t] = sig1(W[t-2]) + W[t-7] + sig0(W[t-15]) + W[t-16]
  assign expand_word = sig1_w + win[9] + sig0_w + win[0];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, input handshake and slot-load decision.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    load_word = expand_word;
    in_ready  = 1'b0;
    case (state_q)
      ST_LOAD: begin
        in_ready = rst_n && slot_free;
        if (in_valid && in_ready) begin
          load      = 1'b1;
          load_word = in_data;
          if (cnt_q == IDX_BLOCK_END) begin
            state_d = ST_EXPAND;
          end
        end
      end
      ST_EXPAND: begin
        if (slot_free) begin
          load = 1'b1;
          if (cnt_q == IDX_SCHED_END) begin
            state_d = ST_LOAD;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Output slot, index counter and 16-word sliding window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      for (int unsigned i = 0; i < BLOCK_WORDS; i++) begin
        win[i] <= '0;
      end
    end else if (load) begin
      cnt_q     <= cnt_q + IDX_W'(1);
      out_valid <= 1'b1;
      out_data  <= load_word;
      out_idx   <= cnt_q;
      out_last  <= (cnt_q == IDX_SCHED_END);
      for (int unsigned i = 0; i < BLOCK_WORDS - 1; i++) begin
        win[i] <= win[i+1];
      end
      win[BLOCK_WORDS-1] <= load_word;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

`ifdef SHA256_SCHED_STALL_CNT_EN
  // Saturating count of back-pressured cycles, restarted with each new block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (load && (state_q == ST_LOAD) && (cnt_q == '0)) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule: table of blocks plus
// back-to-back, mid-block reset and input-blocking sequences.
module tb_sha256_msg_schedule;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_idx;
  logic        out_last;
`ifdef SHA256_SCHED_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  sha256_msg_schedule dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last)
`ifdef SHA256_SCHED_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [5:0]  idx;
    logic        last;
  } exp_t;

  typedef struct {
    logic [15:0][31:0] m;
    bit                kat;
    logic [31:0]       w16;
    logic [31:0]       w17;
    int                mode;
  } vec_t;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] ref_w [64];
  logic [31:0] cap [64];
  int          blk_cnt = 0;
  bit          tp_en = 0;
  int          tp_cnt = 0;
  int          tp_first = 0;
  int          tp_last = 0;
  int          w63_edges[$];
  int          m0_edge = 0;
  int          w0_waits = 0;
  int          ready_mode = 0;
  int          stall_left = 0;
  bit          hold_pend = 0;
  logic [31:0] hold_data;
  logic [5:0]  hold_idx;
  vec_t        tbl [4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic flag_fail(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x};
    return d[n +: 32];
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
  endfunction

  task automatic build_ref(input logic [15:0][31:0] m);
    for (int t = 0; t < 16; t++) ref_w[t] = m[t];
    for (int t = 16; t < 64; t++)
      ref_w[t] = ssig1(ref_w[t-2]) + ref_w[t-7] + ssig0(ref_w[t-15]) + ref_w[t-16];
  endtask

  // Push the expected 64 outputs, then offer the 16 words with in_valid held.
  task automatic send_block(input logic [15:0][31:0] m);
    exp_t e;
    build_ref(m);
    for (int t = 0; t < 64; t++) begin
      e.data = ref_w[t];
      e.idx  = 6'(t);
      e.last = (t == 63);
      sb.push_back(e);
    end
    for (int i = 0; i < 16; i++) begin
      bit acc;
      int guard;
      acc   = 1'b0;
      guard = 0;
      in_valid = 1'b1;
      in_data  = m[i];
      if (i == 0) w0_waits = 0;
      while (!acc) begin
        @(negedge clk);
        acc = in_ready;
        if (acc && i == 0) m0_edge = cyc + 1;
        if (!acc && i == 0) w0_waits++;
        @(posedge clk);
        #1;
        guard++;
        if (!acc && guard > 300) begin
          flag_fail("input_accept");
          return;
        end
      end
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 1000) begin
      @(posedge clk);
      guard++;
    end
    if (sb.size() != 0) flag_fail("drain");
    @(posedge clk);
    #1;
  endtask

  // Consumer back-pressure: always ready, a 5-cycle stall at idx 20, or random.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: begin
        if (stall_left > 0 && out_valid && out_idx == 6'd20) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
        end
      end
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Output monitor: stall hold check and scoreboard compare on each transfer.
  always @(negedge clk) begin
    if (hold_pend) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", out_data, hold_data);
      check("hold_idx", 32'(out_idx), 32'(hold_idx));
    end
    hold_pend = rst_n && out_valid && !out_ready;
    hold_data = out_data;
    hold_idx  = out_idx;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out_idx", 32'(out_idx), 32'hFFFF_FFFF);
      end else begin
        mon_e = sb.pop_front();
        check("out_data", out_data, mon_e.data);
        check("out_idx", 32'(out_idx), 32'(mon_e.idx));
        check("out_last", 32'(out_last), 32'(mon_e.last));
      end
      cap[out_idx] = out_data;
      blk_cnt++;
      if (tp_en) begin
        if (tp_cnt == 0) tp_first = cyc + 1;
        tp_last = cyc + 1;
        tp_cnt++;
      end
      if (out_idx == 6'd63) w63_edges.push_back(cyc + 1);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0][31:0] b1, b2, rb, nb;
    int b2_m0;
    int b2_waits;
    int guard;

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b1;
    ready_mode = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table: zero block, padded "abc", patterned block (random ready), random block (stall at 20)
    tbl[0].m = '0;  tbl[0].kat = 1; tbl[0].w16 = 32'h0;        tbl[0].w17 = 32'h0;        tbl[0].mode = 0;
    tbl[1].m = '0;  tbl[1].kat = 1; tbl[1].w16 = 32'h61626380; tbl[1].w17 = 32'h000F0000; tbl[1].mode = 0;
    tbl[1].m[0]  = 32'h61626380;
    tbl[1].m[15] = 32'h00000018;
    for (int i = 0; i < 16; i++) tbl[2].m[i] = (32'(i) * 32'h01010101) ^ 32'hA5A5_0F0F;
    tbl[2].kat = 0; tbl[2].w16 = '0; tbl[2].w17 = '0; tbl[2].mode = 2;
    for (int i = 0; i < 16; i++) tbl[3].m[i] = $urandom;
    tbl[3].kat = 0; tbl[3].w16 = '0; tbl[3].w17 = '0; tbl[3].mode = 1;

    for (int v = 0; v < 4; v++) begin
      ready_mode = tbl[v].mode;
      if (tbl[v].mode == 1) stall_left = 5;
      blk_cnt = 0;
      send_block(tbl[v].m);
      in_valid = 1'b0;
      drain();
      check("blk_words", 32'(blk_cnt), 32'd64);
      if (tbl[v].kat) begin
        check("kat_w16", cap[16], tbl[v].w16);
        check("kat_w17", cap[17], tbl[v].w17);
      end
`ifdef SHA256_SCHED_STALL_CNT_EN
      if (tbl[v].mode == 1) check("stall_cnt", 32'(stall_cnt), 32'd5);
`endif
    end
    ready_mode = 0;
    @(posedge clk);
    #1;

    // Two blocks back to back, in_valid continuous, out_ready high
    for (int i = 0; i < 16; i++) begin
      b1[i] = $urandom;
      b2[i] = $urandom;
    end
    blk_cnt = 0;
    tp_cnt  = 0;
    tp_en   = 1;
    w63_edges.delete();
    send_block(b1);
    send_block(b2);
    b2_m0    = m0_edge;
    b2_waits = w0_waits;
    in_valid = 1'b0;
    drain();
    tp_en = 0;
    check("b2b_words", 32'(tp_cnt), 32'd128);
    check("b2b_span", 32'(tp_last - tp_first), 32'd127);
    if (w63_edges.size() == 0) flag_fail("b2b_w63");
    else check("b2b_m0_edge", 32'(b2_m0), 32'(w63_edges[0]));
    check("b2b_m0_waits", 32'(b2_waits), 32'd48);

    // Reset at idx 40, then a fresh block
    for (int i = 0; i < 16; i++) begin
      rb[i] = $urandom;
      nb[i] = $urandom;
    end
    send_block(rb);
    in_valid = 1'b0;
    guard = 0;
    do begin
      @(posedge clk);
      #2;
      guard++;
    end while (!(out_valid && out_idx == 6'd40) && guard < 200);
    if (guard >= 200) flag_fail("wait_idx40");
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_out_idx", 32'(out_idx), 32'd0);
    check("mid_rst_out_last", 32'(out_last), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_out_valid2", 32'(out_valid), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    blk_cnt = 0;
    send_block(nb);
    in_valid = 1'b0;
    drain();
    check("post_rst_words", 32'(blk_cnt), 32'd64);
    check("post_rst_w0", cap[0], nb[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
